// File: rtl/minmax_window_16bit.sv
// Windowed statistics over an unsigned 16-bit sample stream.
// Each window collects up to WIN samples and reports max, min, the number of
// rising and falling steps between consecutive samples, and the sample count.
// A window closes after WIN accepts or early on flush. The result is held
// until the downstream side takes it.
module minmax_window_16bit #(
  parameter int unsigned WIN = 8,
  localparam int unsigned CW = $clog2(WIN + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [15:0]   in_data_i,
  input  logic          flush_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [15:0]   out_max_o,
  output logic [15:0]   out_min_o,
  output logic [CW-1:0] out_rise_o,
  output logic [CW-1:0] out_fall_o,
  output logic [CW-1:0] out_count_o
);

  localparam logic [CW-1:0] WinM1 = CW'(WIN - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e state_q, state_d;

  // Working accumulators for the window currently being collected.
  logic [15:0]   acc_max_q, acc_max_d;
  logic [15:0]   acc_min_q, acc_min_d;
  logic [15:0]   acc_prev_q, acc_prev_d;
  logic [CW-1:0] acc_rise_q, acc_rise_d;
  logic [CW-1:0] acc_fall_q, acc_fall_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;

  // Result registers; only these drive the data outputs.
  logic [15:0]   res_max_q;
  logic [15:0]   res_min_q;
  logic [CW-1:0] res_rise_q;
  logic [CW-1:0] res_fall_q;
  logic [CW-1:0] res_cnt_q;

  logic accept;
  logic last_accept;
  logic close_win;

  assign accept      = in_valid_i && in_ready_o;
  // WIN-th sample of the window; the count never passes WIN so no wrap.
  assign last_accept = accept && (state_q == StAccum) && (acc_cnt_q == WinM1);
  // Flush only matters while accumulating; an accept on the same cycle is
  // already folded into the *_d values that get captured.
  assign close_win   = (state_q == StAccum) && (last_accept || flush_i);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // flush is ignored here; WIN >= 2 so one sample never closes a window.
        if (accept) begin
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (close_win) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready_o  = 1'b1;
    out_valid_o = 1'b0;
    unique case (state_q)
      StIdle:  begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b0;
      end
      StAccum: begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b0;
      end
      StHold:  begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b1;
      end
      default: begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b0;
      end
    endcase
  end

  // Accumulator next-state: start a window in idle, fold samples in otherwise.
  always_comb begin
    acc_max_d  = acc_max_q;
    acc_min_d  = acc_min_q;
    acc_prev_d = acc_prev_q;
    acc_rise_d = acc_rise_q;
    acc_fall_d = acc_fall_q;
    acc_cnt_d  = acc_cnt_q;
    if (accept) begin
      if (state_q == StIdle) begin
        acc_max_d  = in_data_i;
        acc_min_d  = in_data_i;
        acc_prev_d = in_data_i;
        acc_rise_d = '0;
        acc_fall_d = '0;
        acc_cnt_d  = CW'(1);
      end else begin
        // Strict compares: ties leave max/min and both step counters alone.
        if (in_data_i > acc_prev_q) begin
          acc_rise_d = acc_rise_q + CW'(1);
        end
        if (in_data_i < acc_prev_q) begin
          acc_fall_d = acc_fall_q + CW'(1);
        end
        if (in_data_i > acc_max_q) begin
          acc_max_d = in_data_i;
        end
        if (in_data_i < acc_min_q) begin
          acc_min_d = in_data_i;
        end
        acc_prev_d = in_data_i;
        acc_cnt_d  = acc_cnt_q + CW'(1);
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_max_q  <= '0;
      acc_min_q  <= '0;
      acc_prev_q <= '0;
      acc_rise_q <= '0;
      acc_fall_q <= '0;
      acc_cnt_q  <= '0;
    end else begin
      acc_max_q  <= acc_max_d;
      acc_min_q  <= acc_min_d;
      acc_prev_q <= acc_prev_d;
      acc_rise_q <= acc_rise_d;
      acc_fall_q <= acc_fall_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  // Capture the closing window; held unchanged through the hold state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_max_q  <= '0;
      res_min_q  <= '0;
      res_rise_q <= '0;
      res_fall_q <= '0;
      res_cnt_q  <= '0;
    end else if (close_win) begin
      res_max_q  <= acc_max_d;
      res_min_q  <= acc_min_d;
      res_rise_q <= acc_rise_d;
      res_fall_q <= acc_fall_d;
      res_cnt_q  <= acc_cnt_d;
    end
  end

  assign out_max_o   = res_max_q;
  assign out_min_o   = res_min_q;
  assign out_rise_o  = res_rise_q;
  assign out_fall_o  = res_fall_q;
  assign out_count_o = res_cnt_q;

endmodule

// File: tb/tb_minmax_window_16bit.sv
// Directed bench for minmax_window_16bit using three instances (WIN = 4, 8, 3).
module tb_minmax_window_16bit;

  logic clk;
  logic rst;

  logic        in_valid  [3];
  logic        flush     [3];
  logic        out_ready [3];
  logic [15:0] in_data   [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [15:0] out_max   [3];
  logic [15:0] out_min   [3];
  logic [3:0]  out_rise  [3];
  logic [3:0]  out_fall  [3];
  logic [3:0]  out_count [3];

  logic [2:0] rise4, fall4, cnt4;
  logic [3:0] rise8, fall8, cnt8;
  logic [1:0] rise3, fall3, cnt3;

  assign out_rise[0]  = {1'b0, rise4};
  assign out_fall[0]  = {1'b0, fall4};
  assign out_count[0] = {1'b0, cnt4};
  assign out_rise[1]  = rise8;
  assign out_fall[1]  = fall8;
  assign out_count[1] = cnt8;
  assign out_rise[2]  = {2'b0, rise3};
  assign out_fall[2]  = {2'b0, fall3};
  assign out_count[2] = {2'b0, cnt3};

  minmax_window_16bit #(.WIN(4)) u_win4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_data_i(in_data[0]), .flush_i(flush[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .out_max_o(out_max[0]), .out_min_o(out_min[0]),
    .out_rise_o(rise4), .out_fall_o(fall4), .out_count_o(cnt4)
  );

  minmax_window_16bit #(.WIN(8)) u_win8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_data_i(in_data[1]), .flush_i(flush[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .out_max_o(out_max[1]), .out_min_o(out_min[1]),
    .out_rise_o(rise8), .out_fall_o(fall8), .out_count_o(cnt8)
  );

  minmax_window_16bit #(.WIN(3)) u_win3 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .in_data_i(in_data[2]), .flush_i(flush[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .out_max_o(out_max[2]), .out_min_o(out_min[2]),
    .out_rise_o(rise3), .out_fall_o(fall3), .out_count_o(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // fmode: 0 = no flush, 1 = flush with the last accept, 2 = flush one cycle later.
  typedef struct {
    int          inst;
    int          n;
    int          fmode;
    logic [15:0] s [8];
    logic [15:0] emax;
    logic [15:0] emin;
    int          erise;
    int          efall;
    int          ecount;
  } row_t;

  function automatic row_t mk(input int inst, input int n, input int fm,
                              input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3,
                              input logic [15:0] a4, input logic [15:0] a5,
                              input logic [15:0] a6, input logic [15:0] a7,
                              input logic [15:0] emax, input logic [15:0] emin,
                              input int er, input int ef, input int ec);
    row_t r;
    r.inst = inst; r.n = n; r.fmode = fm;
    r.s[0] = a0; r.s[1] = a1; r.s[2] = a2; r.s[3] = a3;
    r.s[4] = a4; r.s[5] = a5; r.s[6] = a6; r.s[7] = a7;
    r.emax = emax; r.emin = emin; r.erise = er; r.efall = ef; r.ecount = ec;
    return r;
  endfunction

  // Entered and left at posedge+1; out_ready of the instance must be 1.
  task automatic run_row(input row_t r);
    int k;
    k = r.inst;
    for (int i = 0; i < r.n; i++) begin
      in_valid[k] = 1'b1;
      in_data[k]  = r.s[i];
      flush[k]    = (r.fmode == 1) && (i == r.n - 1);
      @(negedge clk);
      check($sformatf("ready_w%0d_s%0d", k, i), 32'(in_ready[k]), 32'd1);
      check($sformatf("novalid_w%0d_s%0d", k, i), 32'(out_valid[k]), 32'd0);
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    flush[k]    = 1'b0;
    if (r.fmode == 2) begin
      flush[k] = 1'b1;
      @(posedge clk); #1;
      flush[k] = 1'b0;
    end
    @(negedge clk);
    check($sformatf("valid_w%0d", k), 32'(out_valid[k]), 32'd1);
    check($sformatf("max_w%0d", k),   32'(out_max[k]),   32'(r.emax));
    check($sformatf("min_w%0d", k),   32'(out_min[k]),   32'(r.emin));
    check($sformatf("rise_w%0d", k),  32'(out_rise[k]),  32'(r.erise));
    check($sformatf("fall_w%0d", k),  32'(out_fall[k]),  32'(r.efall));
    check($sformatf("count_w%0d", k), 32'(out_count[k]), 32'(r.ecount));
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("valid_1cyc_w%0d", k), 32'(out_valid[k]), 32'd0);
    @(posedge clk); #1;
  endtask

  row_t rows [8];

  initial begin
    rows[0] = mk(0, 4, 0, 5, 9, 9, 2, 0, 0, 0, 0, 16'd9, 16'd2, 1, 1, 4);
    rows[1] = mk(1, 2, 1, 100, 50, 0, 0, 0, 0, 0, 0, 16'd100, 16'd50, 0, 1, 2);
    rows[2] = mk(2, 3, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 0, 0, 0,
                 16'hFFFF, 16'h0000, 1, 1, 3);
    rows[3] = mk(0, 4, 0, 1, 2, 3, 4, 0, 0, 0, 0, 16'd4, 16'd1, 3, 0, 4);
    rows[4] = mk(1, 8, 0, 10, 20, 5, 5, 30, 1, 1, 2, 16'd30, 16'd1, 3, 2, 8);
    rows[5] = mk(2, 3, 0, 7, 7, 7, 0, 0, 0, 0, 0, 16'd7, 16'd7, 0, 0, 3);
    rows[6] = mk(1, 1, 2, 42, 0, 0, 0, 0, 0, 0, 0, 16'd42, 16'd42, 0, 0, 1);
    rows[7] = mk(0, 4, 0, 4, 3, 2, 1, 0, 0, 0, 0, 16'd4, 16'd1, 0, 3, 4);

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; flush[k] = 1'b0; out_ready[k] = 1'b1; in_data[k] = '0;
    end
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_%0d", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("rst_max_%0d", k),   32'(out_max[k]),   32'd0);
      check($sformatf("rst_min_%0d", k),   32'(out_min[k]),   32'd0);
      check($sformatf("rst_count_%0d", k), 32'(out_count[k]), 32'd0);
      check($sformatf("rst_rise_%0d", k),  32'(out_rise[k]),  32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post_rst_ready_%0d", k), 32'(in_ready[k]), 32'd1);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_row(rows[i]);
    end

    // Backpressure: window 1,5,3,8 with out_ready low and in_valid held high.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data[0] = (i == 0) ? 16'd1 : (i == 1) ? 16'd5 : (i == 2) ? 16'd3 : 16'd8;
      @(posedge clk); #1;
    end
    in_data[0] = 16'h0055;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", c), 32'(out_valid[0]), 32'd1);
      check($sformatf("bp_ready_%0d", c), 32'(in_ready[0]),  32'd0);
      check($sformatf("bp_max_%0d", c),   32'(out_max[0]),   32'd8);
      check($sformatf("bp_min_%0d", c),   32'(out_min[0]),   32'd1);
      check($sformatf("bp_count_%0d", c), 32'(out_count[0]), 32'd4);
      check($sformatf("bp_rise_%0d", c),  32'(out_rise[0]),  32'd2);
      check($sformatf("bp_fall_%0d", c),  32'(out_fall[0]),  32'd1);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_valid", 32'(out_valid[0]), 32'd0);
    check("bp_idle_ready", 32'(in_ready[0]),  32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) in_valid[0] = 1'b0;
      @(negedge clk);
      check($sformatf("bp_next_valid_%0d", i), 32'(out_valid[0]), (i == 3) ? 32'd1 : 32'd0);
    end
    check("bp_next_max",   32'(out_max[0]),   32'h55);
    check("bp_next_min",   32'(out_min[0]),   32'h55);
    check("bp_next_count", 32'(out_count[0]), 32'd4);
    check("bp_next_rise",  32'(out_rise[0]),  32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset while holding a result in the WIN=3 instance.
    out_ready[2] = 1'b0;
    in_valid[2]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[2] = 16'(i + 1);
      @(posedge clk); #1;
    end
    in_valid[2] = 1'b0;
    @(negedge clk);
    check("hold_valid", 32'(out_valid[2]), 32'd1);
    check("hold_max",   32'(out_max[2]),   32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("hold_rst_valid", 32'(out_valid[2]), 32'd0);
    check("hold_rst_ready", 32'(in_ready[2]),  32'd1);
    check("hold_rst_max",   32'(out_max[2]),   32'd0);
    check("hold_rst_count", 32'(out_count[2]), 32'd0);
    out_ready[2] = 1'b1;
    @(posedge clk); #1;

    // Reset mid-window: two samples, reset, then a clean 7,7,7,7 window.
    in_valid[0] = 1'b1;
    in_data[0]  = 16'd9;
    @(posedge clk); #1;
    in_data[0]  = 16'd3;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_count", 32'(out_count[0]), 32'd0);
    @(posedge clk); #1;
    run_row(mk(0, 4, 0, 7, 7, 7, 7, 0, 0, 0, 0, 16'd7, 16'd7, 0, 0, 4));

    // Flush in idle is ignored, including on the first accept.
    flush[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("idleflush_valid_%0d", c), 32'(out_valid[1]), 32'd0);
    end
    in_valid[1] = 1'b1;
    in_data[1]  = 16'd3;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    for (int i = 1; i < 8; i++) begin
      in_data[1] = 16'(3 + i);
      @(negedge clk);
      check($sformatf("idleflush_acc_valid_%0d", i), 32'(out_valid[1]), 32'd0);
      @(posedge clk); #1;
    end
    in_valid[1] = 1'b0;
    @(negedge clk);
    check("idleflush_valid",  32'(out_valid[1]), 32'd1);
    check("idleflush_count",  32'(out_count[1]), 32'd8);
    check("idleflush_max",    32'(out_max[1]),   32'd10);
    check("idleflush_min",    32'(out_min[1]),   32'd3);
    check("idleflush_rise",   32'(out_rise[1]),  32'd7);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/minmax_window_16bit.md
MINMAX_WINDOW_16BIT -- requirements
Module: minmax_window_16bit

Interface
REQ-001 Parameter WIN, default 8, number of samples per window; legal range 2..255.
REQ-002 Local width CW SHALL be $clog2(WIN+1) bits.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream sample valid.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 in_data  input  16  unsigned sample.
REQ-008 flush  input  1  close the current window early.
REQ-009 out_valid  output  1  window result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_max  output  16  largest sample in the window, unsigned.
REQ-012 out_min  output  16  smallest sample in the window, unsigned.
REQ-013 out_rise  output  CW  count of samples strictly greater than their predecessor.
REQ-014 out_fall  output  CW  count of samples strictly less than their predecessor.
REQ-015 out_count  output  CW  samples in the window, 1..WIN.

Function
REQ-016 A sample is accepted on a cycle where in_valid && in_ready.
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-019 out_valid SHALL be 1 only in HOLD.
REQ-020 Accept in IDLE:
- max = min = prev = in_data; count = 1; rise = fall = 0;
- next state is ACCUM.
REQ-021 Accept in ACCUM:
- compare in_data with prev, max and min as unsigned 16-bit values;
- if in_data > prev, rise += 1; if in_data < prev, fall += 1; if equal, neither changes;
- max = in_data only when in_data > max; min = in_data only when in_data < min;
- prev = in_data; count += 1.
REQ-022 ACCUM -> HOLD when count reaches WIN on an accept; out_valid SHALL assert the cycle after the WIN-th accept.
REQ-023 flush in ACCUM -> HOLD next cycle with partial results.
REQ-024 flush and an accept in the same ACCUM cycle: the sample is included first, then the window closes.
REQ-025 flush SHALL be ignored in IDLE and in HOLD; an accept in IDLE with flush held SHALL behave as REQ-020 only.
REQ-026 HOLD -> IDLE on out_ready.
REQ-027 Output registers SHALL stay stable while out_valid && !out_ready.
REQ-028 No sample SHALL be accepted in the HOLD->IDLE transition cycle, because in_ready is 0 in HOLD.
REQ-029 rise, fall and count SHALL never exceed WIN-1, WIN-1 and WIN respectively; no wrap occurs.
REQ-030 Ties in max/min SHALL leave the stored value unchanged.
REQ-031 out_* data outputs SHALL be driven directly from the result registers, with no combinational path from in_data.
REQ-032 Throughput is one window per WIN accepts plus at least 1 HOLD cycle.

Reset
REQ-033 rst SHALL put the FSM in IDLE and clear out_valid.
REQ-034 rst SHALL clear out_max, out_min, out_rise, out_fall and out_count to 0, and drive in_ready to 1 from the next cycle.
REQ-035 rst has priority over flush, in_valid and out_ready.
REQ-036 rst asserted mid-window (ACCUM) or in HOLD SHALL discard all partial or pending results with no out_valid pulse.

Verification
REQ-037 Full window: WIN=4, out_ready=1, back-to-back samples 5,9,9,2.
- out_valid for exactly 1 cycle, one cycle after the 4th accept;
- out_max=9, out_min=2, out_rise=1, out_fall=1, out_count=4.
REQ-038 Early flush: WIN=8, samples 100,50 with flush asserted on the 2nd accept.
- out_count=2, out_max=100, out_min=50, out_rise=0, out_fall=1.
REQ-039 Backpressure: complete a window, hold out_ready=0 for 5 cycles, present in_valid=1 throughout.
- out_valid held 5 cycles with outputs constant and in_ready=0;
- the new window starts only after out_ready=1.
REQ-040 Extremes: WIN=3, samples 0xFFFF,0x0000,0xFFFF.
- out_max=0xFFFF, out_min=0x0000, out_rise=1, out_fall=1.
REQ-041 Reset mid-window: WIN=4, 2 samples accepted, rst for 1 cycle, then 4 samples 7,7,7,7.
- exactly one result: max=min=7, rise=fall=0, count=4.
REQ-042 Idle flush: flush pulsed in IDLE, then WIN samples.
- no spurious out_valid;
- normal result with out_count=WIN.
